// File: rtl/cic_decim.sv
// ---------------------------------------------------------------------------
// cic_decim
//   Third-order CIC decimator that turns a 1-bit sigma-delta bitstream into
//   signed PCM samples. Three integrators run at the input rate and three
//   combs (differential delay 1) run once every R = 2**DEC_LOG2 consumed bits.
//   Filter state wraps in two's complement at W = 3*DEC_LOG2+2 bits. Only the
//   final output is shifted and clamped to BW bits.
//
//   Parameters
//     BW        signed PCM output width
//     DEC_LOG2  log2 of the decimation ratio. Legal when 3*DEC_LOG2 >= BW-1
//               and DEC_LOG2 >= 1.
//
//   Ports
//     clk        system clock, rising edge
//     rst        synchronous active-high reset, clears all state
//     bs_in      bitstream sample (1 -> +1, 0 -> -1)
//     bs_en      qualifies bs_in; nothing advances while low
//     pcm_out    decimated sample, held between strobes
//     pcm_valid  one-cycle strobe marking a new pcm_out
// ---------------------------------------------------------------------------
module cic_decim #(
    parameter int BW       = 16,
    parameter int DEC_LOG2 = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bs_in,
    input  logic                 bs_en,
    output logic signed [BW-1:0] pcm_out,
    output logic                 pcm_valid
);

    localparam int W     = 3*DEC_LOG2 + 2;
    // Gain is R**3 = 2**(3*DEC_LOG2). This shift maps full scale onto 2**(BW-1).
    localparam int SHIFT = 3*DEC_LOG2 - BW + 1;

    localparam logic signed [W-1:0] SAT_MAX = {{(W-BW+1){1'b0}}, {(BW-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {{(W-BW+1){1'b1}}, {(BW-1){1'b0}}};

    function automatic logic signed [BW-1:0] sat(input logic signed [W-1:0] v);
        logic signed [BW-1:0] r;
        if (v > SAT_MAX)
            r = SAT_MAX[BW-1:0];
        else if (v < SAT_MIN)
            r = SAT_MIN[BW-1:0];
        else
            r = v[BW-1:0];
        return r;
    endfunction

    logic signed [W-1:0]        i1_q, i2_q, i3_q, i1_d, i2_d, i3_d;
    logic signed [W-1:0]        d0_q, d1_q, d2_q, d0_d, d1_d, d2_d;
    logic        [DEC_LOG2-1:0] cnt_q, cnt_d;
    logic signed [BW-1:0]       pcm_q, pcm_d;
    logic                       vld_q, vld_d;

    logic signed [W-1:0] x;
    logic signed [W-1:0] y0, y1, y2, y3, y3_sh;
    logic                strike;

    assign x      = bs_in ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
    assign strike = bs_en && (cnt_q == {DEC_LOG2{1'b1}});

    // Comb chain works on the pre-edge integrator output.
    assign y0    = i3_q;
    assign y1    = y0 - d0_q;
    assign y2    = y1 - d1_q;
    assign y3    = y2 - d2_q;
    assign y3_sh = y3 >>> SHIFT;

    always_comb begin
        i1_d  = i1_q;
        i2_d  = i2_q;
        i3_d  = i3_q;
        d0_d  = d0_q;
        d1_d  = d1_q;
        d2_d  = d2_q;
        cnt_d = cnt_q;
        pcm_d = pcm_q;
        vld_d = 1'b0;
        if (bs_en) begin
            // Parallel update: every integrator sees the pre-edge value of the one before it.
            i1_d  = i1_q + x;
            i2_d  = i2_q + i1_q;
            i3_d  = i3_q + i2_q;
            cnt_d = cnt_q + 1'b1;
            if (strike) begin
                d0_d  = y0;
                d1_d  = y1;
                d2_d  = y2;
                pcm_d = sat(y3_sh);
                vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i1_q  <= '0;
            i2_q  <= '0;
            i3_q  <= '0;
            d0_q  <= '0;
            d1_q  <= '0;
            d2_q  <= '0;
            cnt_q <= '0;
            pcm_q <= '0;
            vld_q <= 1'b0;
        end else begin
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            i3_q  <= i3_d;
            d0_q  <= d0_d;
            d1_q  <= d1_d;
            d2_q  <= d2_d;
            cnt_q <= cnt_d;
            pcm_q <= pcm_d;
            vld_q <= vld_d;
        end
    end

    assign pcm_out   = pcm_q;
    assign pcm_valid = vld_q;

endmodule

// File: tb/tb_cic_decim.sv
// ---------------------------------------------------------------------------
// tb_cic_decim
//   Directed bench for cic_decim with default parameters (BW=16, DEC_LOG2=6).
//   Expected values are derived by hand from the filter equations. With a
//   constant +1 input, i3 after n bits is C(n,3). The first strike sees n=63,
//   so y3 = 39711 and the output is 39711>>>3 = 4963. The second strike gives
//   y3 = 214242, so the output is 26780. The steady state is 2**18>>>3,
//   clamped to 32767.
// ---------------------------------------------------------------------------
module tb_cic_decim;

    logic               clk = 1'b0;
    logic               rst;
    logic               bs_in;
    logic               bs_en;
    logic signed [15:0] pcm_out;
    logic               pcm_valid;

    int n_checks = 0;
    int n_fail   = 0;

    int strobe_cyc[$];
    int strobe_val[$];
    int e1_sd, e2_sd;

    cic_decim #(.BW(16), .DEC_LOG2(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .bs_in     (bs_in),
        .bs_en     (bs_en),
        .pcm_out   (pcm_out),
        .pcm_valid (pcm_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        bs_en = 1'b0;
        bs_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drives ncyc cycles of a stimulus pattern and records each strobe.
    // Modes: 0 all ones, 1 all zeros, 2 alternating 1/0, 3 enable toggled with ones,
    // and 4 a second-order sigma-delta modulator fed with +8192.
    task automatic run_capture(input int ncyc, input int mode);
        int v;
        strobe_cyc.delete();
        strobe_val.delete();
        for (int c = 0; c < ncyc; c++) begin
            case (mode)
                0: begin bs_en = 1'b1; bs_in = 1'b1; end
                1: begin bs_en = 1'b1; bs_in = 1'b0; end
                2: begin bs_en = 1'b1; bs_in = (c % 2 == 0); end
                3: begin bs_en = (c % 2 == 0); bs_in = 1'b1; end
                default: begin
                    // Error feedback with NTF (1-z^-1)^2, full scale +/-32768.
                    v     = 8192 - 2*e1_sd + e2_sd;
                    bs_en = 1'b1;
                    bs_in = (v >= 0);
                    e2_sd = e1_sd;
                    e1_sd = ((v >= 0) ? 32768 : -32768) - v;
                end
            endcase
            tick();
            if (pcm_valid === 1'b1) begin
                strobe_cyc.push_back(c);
                strobe_val.push_back(int'(pcm_out));
            end
        end
        bs_en = 1'b0;
    endtask

    task automatic test_reset();
        logic saw_vld;
        saw_vld = 1'b0;
        rst   = 1'b1;
        bs_en = 1'b1;
        bs_in = 1'b1;
        for (int c = 0; c < 70; c++) begin
            tick();
            if (pcm_valid !== 1'b0) saw_vld = 1'b1;
        end
        n_checks++;
        if (pcm_out !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_pcm_out: got %0d expected 0", pcm_out);
        end
        n_checks++;
        if (saw_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_valid: got valid=%0b expected 0", saw_vld);
        end
        rst   = 1'b0;
        bs_en = 1'b0;
    endtask

    task automatic test_all_ones();
        do_reset();
        run_capture(8*64, 0);
        n_checks++;
        if (strobe_cyc.size() != 8) begin
            n_fail++;
            $display("FAIL ones_count: got %0d strobes expected 8", strobe_cyc.size());
        end
        if (strobe_cyc.size() > 1) begin
            n_checks++;
            if (strobe_cyc[0] != 63) begin
                n_fail++;
                $display("FAIL ones_first_cycle: got %0d expected 63", strobe_cyc[0]);
            end
            n_checks++;
            if (strobe_val[0] != 4963) begin
                n_fail++;
                $display("FAIL ones_first_value: got %0d expected 4963", strobe_val[0]);
            end
            n_checks++;
            if (strobe_val[1] != 26780) begin
                n_fail++;
                $display("FAIL ones_second_value: got %0d expected 26780", strobe_val[1]);
            end
        end
        for (int k = 1; k < strobe_cyc.size(); k++) begin
            n_checks++;
            if (strobe_cyc[k] - strobe_cyc[k-1] != 64) begin
                n_fail++;
                $display("FAIL ones_spacing[%0d]: got %0d expected 64", k, strobe_cyc[k] - strobe_cyc[k-1]);
            end
        end
        for (int k = 3; k < strobe_val.size(); k++) begin
            n_checks++;
            if (strobe_val[k] != 32767) begin
                n_fail++;
                $display("FAIL ones_value[%0d]: got %0d expected 32767", k, strobe_val[k]);
            end
        end
    endtask

    task automatic test_all_zeros();
        do_reset();
        run_capture(8*64, 1);
        n_checks++;
        if (strobe_val.size() != 8) begin
            n_fail++;
            $display("FAIL zeros_count: got %0d strobes expected 8", strobe_val.size());
        end
        for (int k = 3; k < strobe_val.size(); k++) begin
            n_checks++;
            if (strobe_val[k] != -32768) begin
                n_fail++;
                $display("FAIL zeros_value[%0d]: got %0d expected -32768", k, strobe_val[k]);
            end
        end
    endtask

    task automatic test_alternating();
        do_reset();
        run_capture(8*64, 2);
        n_checks++;
        if (strobe_val.size() != 8) begin
            n_fail++;
            $display("FAIL alt_count: got %0d strobes expected 8", strobe_val.size());
        end
        for (int k = 3; k < strobe_val.size(); k++) begin
            n_checks++;
            if (strobe_val[k] != 0) begin
                n_fail++;
                $display("FAIL alt_value[%0d]: got %0d expected 0", k, strobe_val[k]);
            end
        end
    endtask

    task automatic test_enable_gaps();
        logic saw_vld;
        do_reset();
        run_capture(8*128, 3);
        n_checks++;
        if (strobe_cyc.size() != 8) begin
            n_fail++;
            $display("FAIL gaps_count: got %0d strobes expected 8", strobe_cyc.size());
        end
        if (strobe_cyc.size() > 1) begin
            n_checks++;
            if (strobe_cyc[0] != 126) begin
                n_fail++;
                $display("FAIL gaps_first_cycle: got %0d expected 126", strobe_cyc[0]);
            end
            n_checks++;
            if (strobe_val[0] != 4963 || strobe_val[1] != 26780) begin
                n_fail++;
                $display("FAIL gaps_settling: got %0d,%0d expected 4963,26780", strobe_val[0], strobe_val[1]);
            end
        end
        for (int k = 1; k < strobe_cyc.size(); k++) begin
            n_checks++;
            if (strobe_cyc[k] - strobe_cyc[k-1] != 128) begin
                n_fail++;
                $display("FAIL gaps_spacing[%0d]: got %0d expected 128", k, strobe_cyc[k] - strobe_cyc[k-1]);
            end
        end
        for (int k = 3; k < strobe_val.size(); k++) begin
            n_checks++;
            if (strobe_val[k] != 32767) begin
                n_fail++;
                $display("FAIL gaps_value[%0d]: got %0d expected 32767", k, strobe_val[k]);
            end
        end
        // With the enable low, the output holds and no strobe appears.
        saw_vld = 1'b0;
        bs_en   = 1'b0;
        bs_in   = 1'b0;
        for (int c = 0; c < 150; c++) begin
            tick();
            if (pcm_valid !== 1'b0) saw_vld = 1'b1;
        end
        n_checks++;
        if (saw_vld !== 1'b0 || pcm_out !== 16'sd32767) begin
            n_fail++;
            $display("FAIL gaps_hold: got valid=%0b out=%0d expected valid=0 out=32767", saw_vld, pcm_out);
        end
    endtask

    task automatic test_reset_at_strike();
        do_reset();
        run_capture(4*64 + 63, 0);
        n_checks++;
        if (strobe_val.size() != 4 || pcm_out !== 16'sd32767) begin
            n_fail++;
            $display("FAIL rs_pre: got %0d strobes out=%0d expected 4 strobes out=32767", strobe_val.size(), pcm_out);
        end
        // cnt is now 63, so this enabled cycle would strike if rst were not high.
        rst   = 1'b1;
        bs_en = 1'b1;
        bs_in = 1'b1;
        tick();
        n_checks++;
        if (pcm_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rs_valid: got %0b expected 0", pcm_valid);
        end
        n_checks++;
        if (pcm_out !== 16'sd0) begin
            n_fail++;
            $display("FAIL rs_pcm_out: got %0d expected 0", pcm_out);
        end
        rst = 1'b0;
        run_capture(64, 0);
        n_checks++;
        if (strobe_cyc.size() != 1) begin
            n_fail++;
            $display("FAIL rs_restart_count: got %0d strobes expected 1", strobe_cyc.size());
        end
        if (strobe_cyc.size() > 0) begin
            n_checks++;
            if (strobe_cyc[0] != 63 || strobe_val[0] != 4963) begin
                n_fail++;
                $display("FAIL rs_restart: got cycle %0d value %0d expected cycle 63 value 4963", strobe_cyc[0], strobe_val[0]);
            end
        end
    endtask

    task automatic test_sigma_delta();
        do_reset();
        e1_sd = 0;
        e2_sd = 0;
        run_capture(12*64, 4);
        n_checks++;
        if (strobe_val.size() != 12) begin
            n_fail++;
            $display("FAIL sd_count: got %0d strobes expected 12", strobe_val.size());
        end
        for (int k = 4; k < strobe_val.size(); k++) begin
            n_checks++;
            if (strobe_val[k] < 8192 - 64 || strobe_val[k] > 8192 + 64) begin
                n_fail++;
                $display("FAIL sd_value[%0d]: got %0d expected 8192 +/- 64", k, strobe_val[k]);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        bs_en = 1'b0;
        bs_in = 1'b0;
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_alternating();
        test_enable_gaps();
        test_reset_at_strike();
        test_sigma_delta();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
